bless_port_alloc: RTL
=====================

Name: bless_port_alloc

Overview:
- Output-port allocator stage directly downstream of route computation in the bufferless-deflection (BLESS) router of the 4x4 mesh.
- Consumes the per-input 5-bit desired-port vectors: bit0 +Y, bit1 -Y, bit2 +X, bit3 -X, bit4 eject.
- Assigns every valid in-flight flit exactly one output port, oldest-first, deflecting losers. Admits one local injection when a network port is left free.
- Registered stage: grants are presented one cycle after the inputs are sampled.

Parameters:
- NIN, 4, number of in-flight input channels (fixed at 4; the bench does not vary it)
- AGEBITS, 8, width of each flit age field; a larger value means older
- CNTBITS, 16, width of the deflection statistics counter

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  NIN  per-input flit valid
- in_desired  input  5*NIN  desired vectors from route computation; input i occupies bits [5i+4:5i]
- in_age  input  AGEBITS*NIN  per-input age; input i occupies bits [AGEBITS*i+AGEBITS-1:AGEBITS*i]
- inj_valid  input  1  local injection request
- inj_desired  input  5  desired vector of the injecting flit
- clr_count  input  1  synchronous clear of defl_count
- out_grant  output  5*NIN  registered one-hot granted output port per input; all-zero when the input was invalid
- deflected  output  NIN  registered; granted port was not in the desired set
- inj_grant  output  1  registered; injection accepted
- inj_port  output  5  registered one-hot port given to the injected flit
- defl_count  output  CNTBITS  saturating count of in-flight deflections

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
  - While rst_n=0: all outputs are 0, rr_ptr=0, defl_count=0.
  - Reset asserted mid-operation discards the pending allocation; there is no partial output.
- Latency: inputs sampled at edge N appear on the outputs after edge N+1 and hold for exactly one cycle. There is no handshake; every valid flit must be granted in the cycle it is presented (bufferless).
- Priority order:
  - Valid inputs are sorted by in_age, descending.
  - Equal ages are broken by index, starting at rr_ptr and ascending modulo 4.
  - rr_ptr (2-bit) increments by 1, wrapping 3->0, on every edge where at least two valid inputs share an age.
- Allocation, processed sequentially in priority order:
  - If desired[4]=1, bits [3:0] are ignored. The flit gets eject if eject is still free. Otherwise it gets the lowest-index free network port and is deflected.
  - Otherwise the flit gets the lowest-index free port among desired[3:0].
  - If none of its desired ports is free, it gets the lowest-index free network port and is deflected.
  - A valid flit with desired=0 gets the lowest-index free network port and is counted as deflected.
  - Eject is granted to at most one flit per cycle.
  - Four network ports always cover four inputs, so no valid flit is ever left without a port.
- Injection:
  - Considered only after all in-flight flits are allocated, and only if a network port (0..3) is free.
  - Port choice: the lowest free productive network port in inj_desired[3:0], else the lowest free network port.
  - inj_desired[4] is ignored; injected flits never eject.
  - If no network port is free: inj_grant=0 and the requester retries next cycle.
  - Injection deflections are not counted.
- Counter:
  - defl_count adds the popcount of deflected in-flight flits (0..4) each cycle.
  - It saturates at 2^CNTBITS-1.
  - clr_count has priority and loads 0 on that edge, discarding that cycle's increment.
- Invariants, checked every cycle:
  - out_grant vectors are pairwise disjoint and disjoint from inj_port.
  - Each valid input's grant is exactly one-hot.

Test Plan:
- Single flit, no conflict: in0 valid, desired=00100, age 5 -> next cycle out_grant0=00100, deflected=0000, defl_count unchanged.
- Two-way contention: in0 and in1 both desire 00001, ages 9 and 3 -> in0 gets 00001; in1 gets 00010 with deflected[1]=1; defl_count +1.
- Eject conflict: in2 and in3 desire 10000, ages 4 and 7 -> in3 gets 10000; in2 gets 00001 and is deflected.
- Tie and rotation: all four inputs desire 00001 at age 2 on consecutive cycles, rr_ptr starting at 0.
  - Cycle A: in0 wins port 00001; in1, in2, in3 get 00010, 00100, 01000.
  - Cycle B: in1 wins, rr_ptr=1.
  - defl_count +3 per cycle.
- Injection gating:
  - Four valid flits plus inj_valid -> inj_grant=0.
  - Three valid flits desiring 00001, 00010, 00100 plus inj_desired=00100 -> inj_grant=1, inj_port=01000.
- Counter and reset:
  - Preload near saturation (CNTBITS=4: drive to 15) with further deflections -> stays 15.
  - clr_count=1 with a deflection that cycle -> 0.
  - rst_n low mid-stream -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/bless_port_alloc.sv
// Output-port allocator for the BLESS bufferless-deflection router.
// Stage 1 captures the in-flight flits and the injection request. Stage 2
// allocates ports oldest-first and registers the grants. Every valid flit
// always receives exactly one port.
module bless_port_alloc #(
    parameter int unsigned NIN     = 4,
    parameter int unsigned AGEBITS = 8,
    parameter int unsigned CNTBITS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NIN-1:0]         in_valid,
    input  logic [5*NIN-1:0]       in_desired,
    input  logic [AGEBITS*NIN-1:0] in_age,
    input  logic                   inj_valid,
    input  logic [4:0]             inj_desired,
    input  logic                   clr_count,
    output logic [5*NIN-1:0]       out_grant,
    output logic [NIN-1:0]         deflected,
    output logic                   inj_grant,
    output logic [4:0]             inj_port,
    output logic [CNTBITS-1:0]     defl_count
);

    // Captured request set; this is the allocation that is still pending.
    logic [NIN-1:0]         r_valid;
    logic [5*NIN-1:0]       r_desired;
    logic [AGEBITS*NIN-1:0] r_age;
    logic                   r_inj_valid;
    logic [4:0]             r_inj_desired;
    logic [1:0]             r_rr_ptr;

    logic [1:0]             w_rank  [NIN];
    logic [4:0]             w_free;
    logic [5*NIN-1:0]       w_grant;
    logic [NIN-1:0]         w_defl;
    logic                   w_inj_grant;
    logic [4:0]             w_inj_port;
    logic                   w_tie;
    logic [2:0]             w_pop;
    logic [CNTBITS:0]       w_sum;

    // One-hot of the lowest set bit among the four network ports.
    function automatic logic [4:0] f_low(input logic [3:0] m);
        f_low = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (m[b] && (f_low == 5'd0)) f_low[b] = 1'b1;
        end
    endfunction

    // Capture this cycle's flits and injection request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= '0;
            r_desired     <= '0;
            r_age         <= '0;
            r_inj_valid   <= 1'b0;
            r_inj_desired <= '0;
        end else begin
            r_valid       <= in_valid;
            r_desired     <= in_desired;
            r_age         <= in_age;
            r_inj_valid   <= inj_valid;
            r_inj_desired <= inj_desired;
        end
    end

    // Priority rank per input: count of valid inputs that beat it.
    // Older wins, and equal ages are ordered by distance from rr_ptr.
    always_comb begin
        w_tie = 1'b0;
        for (int unsigned i = 0; i < NIN; i++) begin
            w_rank[i] = '0;
            for (int unsigned j = 0; j < NIN; j++) begin
                if ((j != i) && r_valid[j] && r_valid[i]) begin
                    if (r_age[AGEBITS*j +: AGEBITS] > r_age[AGEBITS*i +: AGEBITS]) begin
                        w_rank[i] = w_rank[i] + 2'd1;
                    end else if (r_age[AGEBITS*j +: AGEBITS] == r_age[AGEBITS*i +: AGEBITS]) begin
                        w_tie = 1'b1;
                        if ((2'(j) - r_rr_ptr) < (2'(i) - r_rr_ptr)) begin
                            w_rank[i] = w_rank[i] + 2'd1;
                        end
                    end
                end
            end
        end
    end

    // Walk the inputs in rank order, then offer a leftover network port to injection.
    always_comb begin
        logic [4:0] des;
        logic [4:0] g;
        w_free      = '1;
        w_grant     = '0;
        w_defl      = '0;
        w_inj_grant = 1'b0;
        w_inj_port  = '0;
        des         = '0;
        g           = '0;
        for (int unsigned k = 0; k < NIN; k++) begin
            for (int unsigned i = 0; i < NIN; i++) begin
                if (r_valid[i] && (w_rank[i] == 2'(k))) begin
                    des = r_desired[5*i +: 5];
                    if (des[4]) begin
                        if (w_free[4]) begin
                            g = 5'b10000;
                        end else begin
                            g = f_low(w_free[3:0]);
                            w_defl[i] = 1'b1;
                        end
                    end else if ((des[3:0] & w_free[3:0]) != 4'd0) begin
                        g = f_low(des[3:0] & w_free[3:0]);
                    end else begin
                        g = f_low(w_free[3:0]);
                        w_defl[i] = 1'b1;
                    end
                    w_grant[5*i +: 5] = g;
                    w_free = w_free & ~g;
                end
            end
        end
        if (r_inj_valid && (w_free[3:0] != 4'd0)) begin
            w_inj_grant = 1'b1;
            if ((r_inj_desired[3:0] & w_free[3:0]) != 4'd0) begin
                w_inj_port = f_low(r_inj_desired[3:0] & w_free[3:0]);
            end else begin
                w_inj_port = f_low(w_free[3:0]);
            end
        end
    end

    // Deflection popcount and saturating sum for the statistics counter.
    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            w_pop = w_pop + {2'b00, w_defl[i]};
        end
        w_sum = {1'b0, defl_count} + (CNTBITS+1)'(w_pop);
    end

    // Register the allocation, advance the tie pointer and update statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_grant  <= '0;
            deflected  <= '0;
            inj_grant  <= 1'b0;
            inj_port   <= '0;
            defl_count <= '0;
            r_rr_ptr   <= '0;
        end else begin
            out_grant <= w_grant;
            deflected <= w_defl;
            inj_grant <= w_inj_grant;
            inj_port  <= w_inj_port;
            if (w_tie) r_rr_ptr <= r_rr_ptr + 2'd1;
            if (clr_count)          defl_count <= '0;
            else if (w_sum[CNTBITS]) defl_count <= '1;
            else                     defl_count <= w_sum[CNTBITS-1:0];
        end
    end

endmodule
